// File: rtl/mm_pkg.sv
// Shared defaults for the FC0 matching memory: field widths, depth, and the
// occupancy counter width helper.
package mm_pkg;

  localparam int MM_KEY_W  = 28;
  localparam int MM_DATA_W = 32;
  localparam int MM_DEPTH  = 16;

  // Counter must represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mm_entry.sv
// One matching-memory cell: valid flop, key/data storage and the key comparator.
module mm_entry
  import mm_pkg::*;
#(
  parameter int KEY_W  = MM_KEY_W,
  parameter int DATA_W = MM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic              clr,
  input  logic [KEY_W-1:0]  wkey,
  input  logic [DATA_W-1:0] wdata,
  input  logic [KEY_W-1:0]  lkey,
  output logic              valid,
  output logic              match,
  output logic [DATA_W-1:0] data
);

  logic [KEY_W-1:0] key_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     valid <= 1'b0;
    else if (clr) valid <= 1'b0;
    else if (set) valid <= 1'b1;
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (set) begin
      key_q <= wkey;
      data  <= wdata;
    end
  end

  assign match = valid & (key_q == lkey);

endmodule

// File: rtl/mm_match_array.sv
// FC0 matching memory: tokens that find their partner leave as a pair, the rest
// wait in the lowest free entry.
module mm_match_array
  import mm_pkg::*;
#(
  parameter int KEY_W  = MM_KEY_W,
  parameter int DATA_W = MM_DATA_W,
  parameter int DEPTH  = MM_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [KEY_W-1:0]  in_key,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [KEY_W-1:0]  out_key,
  output logic [DATA_W-1:0] out_data_a,
  output logic [DATA_W-1:0] out_data_b,
  output logic [IDX_W-1:0]  out_idx,
  output logic [IDX_W:0]    occupancy,
  output logic              full,
  output logic              empty
);

  localparam int OCC_W = occ_width(DEPTH);
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  logic [DEPTH-1:0]  valid_vec, match_vec, set_vec, clr_vec;
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [IDX_W-1:0]  hit_idx, free_idx;
  logic              hit, out_free, accept;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    mm_entry #(.KEY_W(KEY_W), .DATA_W(DATA_W)) u_entry (
      .clk   (clk),
      .rst   (rst),
      .set   (set_vec[g]),
      .clr   (clr_vec[g]),
      .wkey  (in_key),
      .wdata (in_data),
      .lkey  (in_key),
      .valid (valid_vec[g]),
      .match (match_vec[g]),
      .data  (ent_data[g])
    );
  end

  // Downward scans leave the lowest qualifying index as the final assignment.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_vec[i])  hit_idx  = IDX_W'(i);
      if (!valid_vec[i]) free_idx = IDX_W'(i);
    end
  end

  assign hit      = |match_vec;
  assign full     = (occupancy == DEPTH_C);
  assign empty    = (occupancy == '0);
  assign out_free = !out_valid | out_ready;
  assign in_ready = !flush & (hit ? out_free : !full);
  assign accept   = in_valid & in_ready;

  always_comb begin
    set_vec = '0;
    clr_vec = {DEPTH{flush}};
    if (accept && hit)  clr_vec[hit_idx]  = 1'b1;
    if (accept && !hit) set_vec[free_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_key    <= '0;
      out_data_a <= '0;
      out_data_b <= '0;
      out_idx    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept && hit) begin
      out_valid  <= 1'b1;
      out_key    <= in_key;
      out_data_a <= ent_data[hit_idx];
      out_data_b <= in_data;
      out_idx    <= hit_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  occupancy <= '0;
    else if (flush)            occupancy <= '0;
    else if (accept && hit)    occupancy <= occupancy - OCC_W'(1);
    else if (accept)           occupancy <= occupancy + OCC_W'(1);
  end

  // Stored keys are unique, so a lookup may match at most one entry.
  a_single_match: assert property (@(posedge clk) disable iff (!rst) $onehot0(match_vec));

endmodule

// File: tb/tb_mm_match_array.sv
// Self-checking bench for mm_match_array: directed scenarios plus random traffic
// compared against a token-level reference model.
module tb_mm_match_array;

  localparam int KW = 28;
  localparam int DW = 32;
  localparam int D  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [KW-1:0] in_key = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, full, empty;
  logic [KW-1:0] out_key;
  logic [DW-1:0] out_data_a, out_data_b;
  logic [IW-1:0] out_idx;
  logic [IW:0]   occupancy;

  mm_match_array dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_key     (in_key),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_key    (out_key),
    .out_data_a (out_data_a),
    .out_data_b (out_data_b),
    .out_idx    (out_idx),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a set of waiting tokens placed by lowest free slot, plus one pending pair.
  bit            m_v [D];
  logic [KW-1:0] m_k [D];
  logic [DW-1:0] m_d [D];
  bit            m_ov;
  logic [KW-1:0] m_ok;
  logic [DW-1:0] m_oa, m_ob;
  int            m_oi;
  int            m_occ;
  logic          last_rdy;

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_v[i] = 1'b0;
    m_ov = 1'b0; m_ok = '0; m_oa = '0; m_ob = '0; m_oi = 0; m_occ = 0;
  endtask

  function automatic int m_find(input logic [KW-1:0] k);
    for (int i = 0; i < D; i++) if (m_v[i] && m_k[i] == k) return i;
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < D; i++) if (!m_v[i]) return i;
    return -1;
  endfunction

  // Called at the falling edge; drives one cycle of inputs, checks, then advances the model.
  task automatic cycle(input bit v, input logic [KW-1:0] k, input logic [DW-1:0] d,
                       input bit ordy, input bit fl);
    int hi, fi;
    bit rdy;
    in_valid = v; in_key = k; in_data = d; out_ready = ordy; flush = fl;
    #1;
    hi  = m_find(k);
    fi  = m_free();
    rdy = !fl && ((hi >= 0) ? (!m_ov || ordy) : (m_occ < D));
    last_rdy = in_ready;
    check("in_ready",   in_ready,   rdy);
    check("occupancy",  occupancy,  m_occ);
    check("full",       full,       m_occ == D);
    check("empty",      empty,      m_occ == 0);
    check("out_valid",  out_valid,  m_ov);
    check("out_key",    out_key,    m_ok);
    check("out_data_a", out_data_a, m_oa);
    check("out_data_b", out_data_b, m_ob);
    check("out_idx",    out_idx,    m_oi);
    @(posedge clk);
    if (fl) begin
      for (int i = 0; i < D; i++) m_v[i] = 1'b0;
      m_ov = 1'b0; m_occ = 0;
    end else if (v && rdy && hi >= 0) begin
      m_ok = k; m_oa = m_d[hi]; m_ob = d; m_oi = hi; m_ov = 1'b1;
      m_v[hi] = 1'b0; m_occ--;
    end else begin
      if (m_ov && ordy) m_ov = 1'b0;
      if (v && rdy) begin
        m_v[fi] = 1'b1; m_k[fi] = k; m_d[fi] = d; m_occ++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_empty",     empty,     1'b1);
    check("rst_full",      full,      1'b0);
    check("rst_occ",       occupancy, 0);
    @(negedge clk);
    rst = 1'b1;

    // Idle after reset: any key is accepted-ready
    for (int i = 0; i < 4; i++) cycle(1'b0, KW'($urandom), $urandom, 1'b1, 1'b0);

    // Basic pair
    cycle(1'b1, 28'h0000123, 32'hAAAA0001, 1'b1, 1'b0);
    check("pair_occ1", occupancy, 1);
    cycle(1'b1, 28'h0000123, 32'hBBBB0002, 1'b1, 1'b0);
    check("pair_valid", out_valid,  1'b1);
    check("pair_key",   out_key,    28'h0000123);
    check("pair_a",     out_data_a, 32'hAAAA0001);
    check("pair_b",     out_data_b, 32'hBBBB0002);
    check("pair_idx",   out_idx,    0);
    check("pair_occ0",  occupancy,  0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Fill, stall on a new key, free entry 5 with its partner, then the stalled key lands there
    for (int i = 0; i < D; i++) cycle(1'b1, KW'(28'h100 + i), $urandom, 1'b1, 1'b0);
    check("fill_full", full, 1'b1);
    cycle(1'b1, 28'h200, 32'h2000_0000, 1'b1, 1'b0);
    check("stall_ready", last_rdy, 1'b0);
    cycle(1'b1, 28'h105, 32'h1050_0000, 1'b0, 1'b0);
    check("full_hit_valid", out_valid, 1'b1);
    check("full_hit_idx",   out_idx,   5);
    cycle(1'b1, 28'h200, 32'h2000_0000, 1'b1, 1'b0);
    cycle(1'b1, 28'h200, 32'h2000_0001, 1'b1, 1'b0);
    check("restore_idx", out_idx, 5);
    check("restore_a",   out_data_a, 32'h2000_0000);
    cycle(1'b0, '0, '0, 1'b1, 1'b1);

    // Backpressure on the output register
    cycle(1'b1, 28'h300, 32'h3000_0000, 1'b1, 1'b0);
    cycle(1'b1, 28'h301, 32'h3010_0000, 1'b1, 1'b0);
    cycle(1'b1, 28'h300, 32'h3000_0001, 1'b0, 1'b0);
    cycle(1'b1, 28'h301, 32'h3010_0001, 1'b0, 1'b0);
    check("bp_ready", last_rdy, 1'b0);
    check("bp_hold_key", out_key, 28'h300);
    cycle(1'b1, 28'h301, 32'h3010_0001, 1'b1, 1'b0);
    check("bp_ready_up", last_rdy, 1'b1);
    check("bp_second_key", out_key, 28'h301);
    check("bp_second_b",   out_data_b, 32'h3010_0001);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with a pending pair and a concurrent token
    for (int i = 0; i < 8; i++) cycle(1'b1, KW'(28'h400 + i), $urandom, 1'b1, 1'b0);
    cycle(1'b1, 28'h500, 32'h5000_0000, 1'b1, 1'b0);
    cycle(1'b1, 28'h500, 32'h5000_0001, 1'b0, 1'b0);
    cycle(1'b1, 28'h600, 32'h6000_0000, 1'b0, 1'b1);
    check("flush_occ",   occupancy, 0);
    check("flush_valid", out_valid, 1'b0);
    cycle(1'b1, 28'h600, 32'h6000_0001, 1'b1, 1'b0);
    check("flush_not_stored", out_valid, 1'b0);
    check("flush_occ1", occupancy, 1);

    // Random traffic over a small key pool so hits, misses, full and backpressure all occur
    for (int n = 0; n < 3000; n++)
      cycle($urandom_range(0, 9) < 7, KW'($urandom_range(0, 19)), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 99) < 2);

    // Asynchronous reset with a pair pending
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    cycle(1'b1, 28'h700, 32'h7000_0000, 1'b0, 1'b0);
    cycle(1'b1, 28'h701, 32'h7010_0000, 1'b0, 1'b0);
    cycle(1'b1, 28'h700, 32'h7000_0001, 1'b0, 1'b0);
    check("pre_rst_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_occ",   occupancy, 0);
    check("async_rst_empty", empty,     1'b1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, 28'h701, 32'h7010_0001, 1'b1, 1'b0);
    check("post_rst_miss_valid", out_valid, 1'b0);
    check("post_rst_miss_occ",   occupancy, 1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
